// File: rtl/dfc_rx_buffer.sv
// Receive-side buffer: converts delayed-flow-control input (c_vld/c_data, c_fc_n)
// to srdy/drdy, using a FIFO sized for the transmitter round-trip latency.
`timescale 1ns/1ps
module dfc_rx_buffer #(
    parameter int width    = 8,
    parameter int rt_lat   = 5,
    parameter int thd      = 1,
    parameter int regcout  = 1,
    parameter int regcin   = 0,
    parameter int usage_sz = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c_vld,
    output logic                c_fc_n,
    input  logic [width-1:0]    c_data,
    input  logic                force_stop,
    output logic                p_srdy,
    input  logic                p_drdy,
    output logic [width-1:0]    p_data,
    output logic                overflow,
    output logic [usage_sz-1:0] usage
);

    localparam int depth = rt_lat + thd + regcout + regcin + 1;
    localparam int usz   = $clog2(depth + 1);
    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int uw    = (usage_sz > usz) ? usage_sz : usz;

    localparam logic [usz-1:0]   DEPTH_U   = usz'(depth);
    localparam logic [usz-1:0]   THD_U     = usz'(thd);
    localparam logic [ptr_w-1:0] PTR_LAST  = ptr_w'(depth - 1);
    localparam logic [uw-1:0]    USAGE_MAX = uw'({usage_sz{1'b1}});

    // Clamp the internal occupancy into the (possibly narrower) usage port.
    function automatic logic [usage_sz-1:0] sat_usage(input logic [usz-1:0] u);
        logic [uw-1:0] ext;
        ext = uw'(u);
        if (ext > USAGE_MAX)
            sat_usage = {usage_sz{1'b1}};
        else
            sat_usage = ext[usage_sz-1:0];
    endfunction

    // Pointers wrap at depth, which need not be a power of two.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        if (p == PTR_LAST)
            next_ptr = '0;
        else
            next_ptr = p + 1'b1;
    endfunction

    logic             f_srdy;
    logic [width-1:0] f_data;
    logic             f_drdy;

    generate
        if (regcin != 0) begin : g_regcin
            logic             in_vld_q;
            logic             in_vld_d;
            logic [width-1:0] in_data_q;

            always_comb begin
                in_vld_d = c_vld;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    in_vld_q <= 1'b0;
                else
                    in_vld_q <= in_vld_d;
            end

            always_ff @(posedge clk) begin
                in_data_q <= c_data;
            end

            assign f_srdy = in_vld_q;
            assign f_data = in_data_q;
        end else begin : g_nocin
            assign f_srdy = c_vld;
            assign f_data = c_data;
        end
    endgenerate

    logic [width-1:0]    mem_q [depth];
    logic [ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [usz-1:0]      f_usage_q, f_usage_d;
    logic                overflow_q, overflow_d;
    logic [usage_sz-1:0] usage_q, usage_d;
    logic                full, empty, push, pop, fc_next;

    always_comb begin
        full       = (f_usage_q == DEPTH_U);
        empty      = (f_usage_q == '0);
        f_drdy     = ~full;
        push       = f_srdy & f_drdy;
        pop        = ~empty & p_drdy;
        wr_ptr_d   = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        f_usage_d  = f_usage_q;
        if (push & ~pop)
            f_usage_d = f_usage_q + 1'b1;
        else if (pop & ~push)
            f_usage_d = f_usage_q - 1'b1;
        // A full FIFO refuses the write even when a pop frees a slot this cycle.
        overflow_d = f_srdy & full;
        usage_d    = sat_usage(f_usage_q);
        fc_next    = ~force_stop & (f_usage_q < THD_U);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            f_usage_q  <= '0;
            overflow_q <= 1'b0;
            usage_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            f_usage_q  <= f_usage_d;
            overflow_q <= overflow_d;
            usage_q    <= usage_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= f_data;
    end

    generate
        if (regcout != 0) begin : g_regcout
            logic fc_q;
            logic fc_d;

            always_comb begin
                fc_d = fc_next;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    fc_q <= 1'b0;
                else
                    fc_q <= fc_d;
            end

            assign c_fc_n = fc_q;
        end else begin : g_nocout
            assign c_fc_n = ~rst & fc_next;
        end
    endgenerate

    assign p_srdy   = ~empty;
    assign p_data   = mem_q[rd_ptr_q];
    assign overflow = overflow_q;
    assign usage    = usage_q;

endmodule

// File: tb/tb_dfc_rx_buffer.sv
// Scoreboard bench for dfc_rx_buffer at default parameters (depth 8, usage saturates at 7).
`timescale 1ns/1ps
module tb_dfc_rx_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       c_vld;
    logic       c_fc_n;
    logic [7:0] c_data;
    logic       force_stop;
    logic       p_srdy;
    logic       p_drdy;
    logic [7:0] p_data;
    logic       overflow;
    logic [2:0] usage;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    dfc_rx_buffer dut (
        .clk(clk), .rst(rst), .c_vld(c_vld), .c_fc_n(c_fc_n), .c_data(c_data),
        .force_stop(force_stop), .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
        .overflow(overflow), .usage(usage)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit accepted);
        c_vld  = 1'b1;
        c_data = d;
        if (accepted) exp_q.push_back(d);
    endtask

    // Monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && p_srdy && p_drdy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", p_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (p_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h", p_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; c_vld = 1'b0; c_data = '0; force_stop = 1'b0; p_drdy = 1'b0;
        tick(); tick();
        check("rst_srdy", p_srdy, 0);
        check("rst_fc", c_fc_n, 0);
        check("rst_usage", usage, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();
        check("rel_fc", c_fc_n, 1);

        // Single word with consumer ready
        p_drdy = 1'b1;
        send(8'hA5, 1'b1);
        tick();
        c_vld = 1'b0;
        check("single_srdy", p_srdy, 1);
        check("single_data", p_data, 8'hA5);
        check("single_fc_hi", c_fc_n, 1);
        check("single_usage0", usage, 0);
        tick();
        check("single_srdy_off", p_srdy, 0);
        check("single_fc_dip", c_fc_n, 0);
        check("single_usage1", usage, 1);
        tick();
        check("single_fc_back", c_fc_n, 1);
        check("single_usage_back", usage, 0);

        // Burst fill with consumer stalled
        p_drdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b1);
            tick();
            check("burst_fc", c_fc_n, (i == 1) ? 1 : 0);
            check("burst_usage", usage, (i - 1 > 7) ? 7 : i - 1);
            check("burst_ovf", overflow, 0);
        end
        c_vld = 1'b0;
        tick();
        check("burst_usage_sat", usage, 7);
        check("burst_srdy", p_srdy, 1);

        // Overflow while full, then while full and popping
        send(8'h09, 1'b0);
        tick();
        c_vld = 1'b0;
        check("ovf1", overflow, 1);
        tick();
        check("ovf1_clear", overflow, 0);
        p_drdy = 1'b1;
        send(8'h09, 1'b0);
        tick();
        c_vld = 1'b0;
        check("ovf2", overflow, 1);
        n = 0;
        while (p_srdy && n < 20) begin
            tick();
            n++;
        end
        check("drain_done", p_srdy, 0);
        check("drain_fc_low", c_fc_n, 0);
        tick();
        check("drain_fc_back", c_fc_n, 1);
        check("drain_usage", usage, 0);
        check("drain_queue_empty", exp_q.size(), 0);

        // force_stop override
        force_stop = 1'b1;
        tick();
        check("fs_low", c_fc_n, 0);
        force_stop = 1'b0;
        tick();
        check("fs_release", c_fc_n, 1);

        // Streaming across pointer wraps
        for (int i = 0; i < 20; i++) begin
            send(8'h40 + 8'(i), 1'b1);
            tick();
            check("stream_usage", {31'd0, usage <= 3'd1}, 1);
            check("stream_ovf", overflow, 0);
        end
        c_vld = 1'b0;
        tick(); tick();
        check("stream_queue_empty", exp_q.size(), 0);
        check("stream_srdy_off", p_srdy, 0);

        // Asynchronous reset in the middle of a cycle with data pending
        p_drdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(8'hC0 + 8'(i), 1'b1);
            tick();
        end
        c_vld = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #2;
        check("mid_rst_srdy", p_srdy, 0);
        check("mid_rst_fc", c_fc_n, 0);
        check("mid_rst_usage", usage, 0);
        check("mid_rst_ovf", overflow, 0);
        tick();
        rst = 1'b0;
        p_drdy = 1'b1;
        tick();
        check("post_rst_fc", c_fc_n, 1);
        check("post_rst_srdy", p_srdy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
